fetch_unit: RTL and testbench

- Instruction prefetch stage placed directly upstream of the multi-cycle CPU decode stage.
- Issues sequential word reads to instruction memory and buffers the returned words with their addresses in a small queue.
- Presents the queue head to decode over a valid/ready handshake.
- On a control-flow redirect, flushes the queue and drops any responses still in flight.

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 88 ++++++++
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared constants and helpers for the instruction fetch stage.
//            Default data and address widths, queue depth, reset fetch
//            address, and a helper that sizes occupancy counters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int c_DEF_BITS_DATA = 32;
    localparam int c_DEF_BITS_ADDR = 16;
    localparam int c_DEF_DEPTH     = 4;
    localparam int c_DEF_RESET_PC  = 0;

    // Width of a counter that has to hold every value 0..depth inclusive.
    // depth is a power of two, so one bit above the pointer width is enough.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Synchronous FIFO holding {pc, instruction} entries for the
//            fetch stage. The head entry is read straight from registered
//            storage. flush empties the queue and overrides push and pop.
// Ports    : clk, reset (async, active-high)
//            push/din  - write an entry (ignored when full without a pop)
//            pop       - remove the head entry (ignored when empty)
//            flush     - clear pointers and occupancy
//            dout      - head entry
//            count     - occupancy, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [WIDTH-1:0]            din,
    input  logic                        pop,
    input  logic                        flush,
    output logic [WIDTH-1:0]            dout,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = pop && (count_q != '0);
    // When full, a push is only accepted alongside a pop; the slot being
    // written is the one that is consumed on the same edge.
    assign w_do_push = push && ((count_q != CNT_W'(DEPTH)) || w_do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: count gates its visibility.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction prefetch stage. Issues sequential word reads,
//            queues returned words with their addresses and hands the queue
//            head to decode over valid/ready. A redirect flushes the queue
//            and drops responses that are still in flight.
// Ports    : clk, reset (async, active-high)
//            mem_rd/mem_addr        - one-cycle read request to memory
//            mem_rdata/mem_rvalid   - in-order read responses
//            ir_valid/ir_data/ir_pc - queue head towards decode
//            ir_ready               - decode accepts the head
//            redirect/redirect_pc   - restart fetch at a new address
//            halt                   - suppress new requests
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                   BITS_DATA = c_DEF_BITS_DATA,
    parameter int                   BITS_ADDR = c_DEF_BITS_ADDR,
    parameter int                   DEPTH     = c_DEF_DEPTH,
    parameter logic [BITS_ADDR-1:0] RESET_PC  = BITS_ADDR'(c_DEF_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 mem_rd,
    output logic [BITS_ADDR-1:0] mem_addr,
    input  logic [BITS_DATA-1:0] mem_rdata,
    input  logic                 mem_rvalid,
    output logic                 ir_valid,
    output logic [BITS_DATA-1:0] ir_data,
    output logic [BITS_ADDR-1:0] ir_pc,
    input  logic                 ir_ready,
    input  logic                 redirect,
    input  logic [BITS_ADDR-1:0] redirect_pc,
    input  logic                 halt
);

    localparam int CNT_W   = cnt_width(DEPTH);
    localparam int ENTRY_W = BITS_ADDR + BITS_DATA;

    logic [BITS_ADDR-1:0] fetch_pc_q, fetch_pc_d;
    logic [BITS_ADDR-1:0] resp_pc_q, resp_pc_d;
    logic [BITS_ADDR-1:0] mem_addr_q, mem_addr_d;
    logic                 mem_rd_q, mem_rd_d;
    logic [CNT_W-1:0]     outstanding_q, outstanding_d;
    logic [CNT_W-1:0]     discard_q, discard_d;

    logic [CNT_W-1:0]     w_fifo_count;
    logic [ENTRY_W-1:0]   w_fifo_dout;
    logic [CNT_W:0]       w_inflight;
    logic                 w_issue;
    logic                 w_rsp;
    logic                 w_push;
    logic                 w_pop;

    // Every word in the queue or in flight holds a credit, so a response
    // always finds a free slot.
    assign w_inflight = {1'b0, w_fifo_count} + {1'b0, outstanding_q};
    assign w_issue    = !redirect && !halt && (w_inflight < (CNT_W+1)'(DEPTH));

    // A stray strobe with nothing outstanding is ignored.
    assign w_rsp      = mem_rvalid && (outstanding_q != '0);

    assign ir_valid   = (w_fifo_count != '0);
    assign w_pop      = ir_valid && ir_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        mem_addr_d    = mem_addr_q;
        mem_rd_d      = 1'b0;
        discard_d     = discard_q;
        w_push        = 1'b0;
        outstanding_d = outstanding_q + CNT_W'(w_issue) - CNT_W'(w_rsp);

        if (w_issue) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + BITS_ADDR'(1);
        end

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            // Everything still in flight belongs to the old stream. A
            // response landing this cycle is dropped here directly.
            discard_d  = outstanding_q - CNT_W'(w_rsp);
        end else if (w_rsp) begin
            if (discard_q != '0) begin
                discard_d = discard_q - CNT_W'(1);
            end else begin
                w_push    = 1'b1;
                resp_pc_d = resp_pc_q + BITS_ADDR'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            mem_addr_q    <= '0;
            mem_rd_q      <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_q      <= mem_rd_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   ({resp_pc_q, mem_rdata}),
        .pop   (w_pop),
        .flush (redirect),
        .dout  (w_fifo_dout),
        .count (w_fifo_count)
    );

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign ir_pc    = w_fifo_dout[ENTRY_W-1:BITS_DATA];
    assign ir_data  = w_fifo_dout[BITS_DATA-1:0];

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit with a
//            fixed-latency memory model (mem[a] = 0xA000_0000 + a).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        ir_valid;
    logic [31:0] ir_data;
    logic [15:0] ir_pc;
    logic        ir_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        halt = 1'b0;

    int checks   = 0;
    int failures = 0;
    int lat      = 2;

    logic [31:0] dpc[$];
    logic [31:0] ddata[$];
    logic [31:0] rda[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .ir_valid    (ir_valid),
        .ir_data     (ir_data),
        .ir_pc       (ir_pc),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    // Memory: a request visible after edge k is answered before edge k+lat.
    logic [3:0]  pv;
    logic [15:0] pa [4];
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            pv <= '0;
            for (int i = 0; i < 4; i++) pa[i] <= '0;
        end else begin
            pv <= {pv[2:0], mem_rd};
            for (int i = 3; i > 0; i--) pa[i] <= pa[i-1];
            pa[0] <= mem_addr;
        end
    end
    assign mem_rvalid = pv[lat-1];
    assign mem_rdata  = 32'hA000_0000 + {16'h0, pa[lat-1]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: log the handshake that will happen on this edge, then
    // sample outputs 1 time unit after the edge.
    task automatic cycle();
        if (ir_valid && ir_ready && !redirect) begin
            dpc.push_back({16'h0, ir_pc});
            ddata.push_back(ir_data);
        end
        @(posedge clk);
        #1;
        if (mem_rd) rda.push_back({16'h0, mem_addr});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        halt     = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        dpc.delete(); ddata.delete(); rda.delete();
    endtask

    initial begin
        // ---- streaming, latency 2 ----
        lat = 2; ir_ready = 1'b1;
        do_reset();
        chk("rst_mem_rd", {31'h0, mem_rd}, 32'd0);
        chk("rst_mem_addr", {16'h0, mem_addr}, 32'd0);
        chk("rst_ir_valid", {31'h0, ir_valid}, 32'd0);
        run(14);
        chk("stream_issue_cnt", 32'(rda.size()), 32'd14);
        chk("stream_deliv_cnt", 32'(dpc.size()), 32'd11);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("stream_pc%0d", i), dpc[i], 32'(i));
            chk($sformatf("stream_data%0d", i), ddata[i], 32'hA000_0000 + 32'(i));
        end
        chk("stream_rda13", rda[13], 32'd13);
        chk("stream_rd_high", {31'h0, mem_rd}, 32'd1);
        // asynchronous reset between edges while streaming
        #3; reset = 1'b1; #1;
        chk("async_rst_mem_rd", {31'h0, mem_rd}, 32'd0);
        chk("async_rst_ir_valid", {31'h0, ir_valid}, 32'd0);
        chk("async_rst_mem_addr", {16'h0, mem_addr}, 32'd0);

        // ---- backpressure ----
        lat = 2; ir_ready = 1'b0;
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (i >= 4) chk($sformatf("bp_head_pc_c%0d", i), {16'h0, ir_pc}, 32'd0);
        end
        chk("bp_req_cnt", 32'(rda.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("bp_addr%0d", i), rda[i], 32'(i));
        chk("bp_rd_low", {31'h0, mem_rd}, 32'd0);
        chk("bp_valid", {31'h0, ir_valid}, 32'd1);
        chk("bp_head_data", ir_data, 32'hA000_0000);
        ir_ready = 1'b1;
        run(8);
        for (int i = 0; i < 5; i++) chk($sformatf("bp_rel_pc%0d", i), dpc[i], 32'(i));

        // ---- redirect with three requests in flight, latency 3 ----
        lat = 3; ir_ready = 1'b1;
        do_reset();
        run(3);
        redirect = 1'b1; redirect_pc = 16'h0100;
        cycle();
        redirect = 1'b0;
        chk("redir_valid_low", {31'h0, ir_valid}, 32'd0);
        chk("redir_no_old", 32'(dpc.size()), 32'd0);
        rda.delete();
        run(12);
        chk("redir_first_addr", rda[0], 32'h0100);
        chk("redir_pc0", dpc[0], 32'h0100);
        chk("redir_data0", ddata[0], 32'hA000_0100);
        chk("redir_pc1", dpc[1], 32'h0101);

        // ---- address wrap ----
        lat = 1; ir_ready = 1'b1;
        do_reset();
        run(3);
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        cycle();
        redirect = 1'b0;
        dpc.delete(); ddata.delete();
        run(10);
        chk("wrap_pc0", dpc[0], 32'hFFFE);
        chk("wrap_pc1", dpc[1], 32'hFFFF);
        chk("wrap_pc2", dpc[2], 32'h0000);
        chk("wrap_pc3", dpc[3], 32'h0001);
        chk("wrap_data1", ddata[1], 32'hA000_FFFF);
        chk("wrap_data3", ddata[3], 32'hA000_0001);

        // ---- halt after two requests ----
        lat = 2; ir_ready = 1'b1;
        do_reset();
        run(2);
        halt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk($sformatf("halt_rd_low_c%0d", i), {31'h0, mem_rd}, 32'd0);
        end
        chk("halt_req_cnt", 32'(rda.size()), 32'd2);
        chk("halt_deliv_cnt", 32'(dpc.size()), 32'd2);
        chk("halt_pc1", dpc[1], 32'd1);
        halt = 1'b0;
        cycle();
        chk("halt_resume_rd", {31'h0, mem_rd}, 32'd1);
        chk("halt_resume_addr", {16'h0, mem_addr}, 32'd2);

        // ---- async reset with a full queue ----
        lat = 1; ir_ready = 1'b0;
        do_reset();
        run(8);
        chk("full_valid", {31'h0, ir_valid}, 32'd1);
        chk("full_req_cnt", 32'(rda.size()), 32'd4);
        #3; reset = 1'b1; #1;
        chk("full_rst_valid", {31'h0, ir_valid}, 32'd0);
        chk("full_rst_rd", {31'h0, mem_rd}, 32'd0);
        do_reset();
        cycle();
        chk("post_rst_rd", {31'h0, mem_rd}, 32'd1);
        chk("post_rst_addr", {16'h0, mem_addr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
